ab_detect_arbiter: RTL and testbench
====================================

AB_DETECT_ARBITER -- requirements
Module: ab_detect_arbiter

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing one A-then-B sequence detector; supported value 4 only.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  N_REQ  per-requester transaction request, level.
REQ-005 Port: a_in  input  N_REQ  per-requester A sample.
REQ-006 Port: b_in  input  N_REQ  per-requester B sample.
REQ-007 Port: gnt  output  N_REQ  one-hot grant; all-zero when no transaction is in progress.
REQ-008 Port: busy  output  1  high while a transaction is in progress.
REQ-009 Port: done  output  1  one-cycle result strobe.
REQ-010 Port: hit  output  1  result; qualified by done, 0 otherwise.
REQ-011 Port: done_id  output  2  index of the requester whose result is on hit; qualified by done, 0 otherwise.

Function
REQ-012 Controller FSM states: IDLE, SAMP_A, SAMP_B, REPORT; state transitions occur only on clk edges.
REQ-013 IDLE: if any req bit is 1, grant the winner, clear the detector to S0, go to SAMP_A; otherwise stay in IDLE.
REQ-014 Arbitration: round-robin, searching from (last_id+1) mod 4 upward with wrap; last_id updates to the winner at grant.
REQ-015 SAMP_A: detector steps once on a_in[g]; go to SAMP_B unconditionally.
REQ-016 SAMP_B: detector steps once on b_in[g]; go to REPORT unconditionally.
REQ-017 Detector (Moore): S0 --A=1--> S1; S0 --A=0--> S0; S1 --B=1--> S2; S1 --B=0--> S0; S2 --> S0; match output is 1 only in S2.
REQ-018 REPORT: done=1, hit=detector match, done_id=g; go to IDLE.
REQ-019 Latency: a request seen in IDLE at edge k gives done high in cycle k+3; the minimum period between grants is 4 cycles.
REQ-020 gnt[g] and busy are high in SAMP_A, SAMP_B and REPORT; both are low in IDLE.
REQ-021 Only the granted requester's a_in/b_in are observed; other bits of a_in/b_in are ignored.
REQ-022 req[g] deasserted mid-transaction: the transaction still completes and reports normally; no abort.
REQ-023 A new req rising during a transaction waits; it is considered at the next IDLE cycle.
REQ-024 Simultaneous requests: exactly one grant, per REQ-014; losers remain pending while their req is held.
REQ-025 X or Z on the req, a_in or b_in bits of non-granted requesters SHALL NOT affect any output.

Reset
REQ-026 rst_n low: FSM=IDLE, detector=S0, last_id=3 (so requester 0 wins first), gnt=0, busy=0, done=0, hit=0, done_id=0, all asynchronously.
REQ-027 Reset asserted mid-transaction: the transaction is discarded with no done pulse; after release, arbitration restarts per REQ-026.
REQ-028 Reset deassertion is synchronised externally; the block does not resynchronise rst_n.

Structure
REQ-029 The shared package holds the FSM state encoding (IDLE=2'b00, SAMP_A=2'b01, SAMP_B=2'b10, REPORT=2'b11), the detector state encoding (S0=2'b00, S1=2'b01, S2=2'b10) and N_REQ.
REQ-030 The detector is a sub-module, ab_seq_det, with ports clk, rst_n, clr (sync to S0), step, a, b and match; it steps only when step=1.
REQ-031 The round-robin selection is combinational logic inside ab_detect_arbiter; it has no separate module.
REQ-032 The outputs gnt, busy, done, hit and done_id are driven directly from registers or from a state decode; no input reaches any output combinationally.

Verification
REQ-033 Reset, then req=0001, a_in[0]=1 in SAMP_A, b_in[0]=1 in SAMP_B -> gnt=0001 for 3 cycles, done at k+3, hit=1, done_id=0.
REQ-034 req=0100, a_in[2]=1, b_in[2]=0 -> hit=0, done_id=2; a_in[2]=0, b_in[2]=1 -> hit=0.
REQ-035 req=1111 held continuously -> grant order 0,1,2,3,0 with a grant every 4 cycles; done_id follows the same sequence.
REQ-036 req[1] pulsed for 1 cycle in IDLE, a_in[1]=1 and b_in[1]=1 -> transaction completes, done=1, hit=1, done_id=1 despite req low.
REQ-037 rst_n low during SAMP_B -> no done pulse; after release with req=0010 the first grant is requester 0 only if req[0]=1, otherwise requester 1.
REQ-038 Granted requester 3 with a_in=0111 and b_in=0111 -> hit=0; the other requesters' inputs have no effect.

Source files
------------

// File: rtl/ab_detect_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ab_detect_arbiter_pkg : shared encodings for the A-then-B detect arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ab_detect_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  // Controller FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_SAMP_A = 2'b01;
  localparam logic [1:0] ST_SAMP_B = 2'b10;
  localparam logic [1:0] ST_REPORT = 2'b11;

  // Detector encoding
  localparam logic [1:0] DET_S0 = 2'b00;
  localparam logic [1:0] DET_S1 = 2'b01;
  localparam logic [1:0] DET_S2 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ab_detect_arbiter_seq_det.sv
// ---------------------------------------------------------------------------
// ab_seq_det : Moore A-then-B sequence detector, steps only when step=1
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ab_seq_det
  import ab_detect_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic a,
  input  logic b,
  output logic match
);

  logic [1:0] state_q;
  logic [1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DET_S0;
    end else if (step) begin
      case (state_q)
        DET_S0:  state_d = a ? DET_S1 : DET_S0;
        DET_S1:  state_d = b ? DET_S2 : DET_S0;
        default: state_d = DET_S0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DET_S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign match = (state_q == DET_S2);

endmodule

`default_nettype wire

// File: rtl/ab_detect_arbiter.sv
// ---------------------------------------------------------------------------
// ab_detect_arbiter : round-robin arbiter sharing one A-then-B detector
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ab_detect_arbiter
  import ab_detect_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a_in,
  input  logic [N_REQ-1:0] b_in,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [ID_W-1:0]  done_id
);

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] last_id_q, last_id_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_id;

  logic det_clr, det_step, det_a, det_b, det_match;

  // Search starts just after the last winner; the 2-bit add wraps mod 4.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_id_q;
    scan_id   = last_id_q;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_id = last_id_q + ID_W'(i);
      if (!win_found && req[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    last_id_d = last_id_q;
    det_clr   = 1'b0;
    det_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gid_d     = win_id;
          last_id_d = win_id;
          det_clr   = 1'b1;
          state_d   = ST_SAMP_A;
        end
      end
      ST_SAMP_A: begin
        det_step = 1'b1;
        state_d  = ST_SAMP_B;
      end
      ST_SAMP_B: begin
        det_step = 1'b1;
        state_d  = ST_REPORT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the phase-relevant sample of the granted requester reaches the detector.
  assign det_a = (state_q == ST_SAMP_A) & a_in[gid_q];
  assign det_b = (state_q == ST_SAMP_B) & b_in[gid_q];

  ab_seq_det u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (det_clr),
    .step  (det_step),
    .a     (det_a),
    .b     (det_b),
    .match (det_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gid_q     <= '0;
      last_id_q <= ID_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      gid_q     <= gid_d;
      last_id_q <= last_id_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign gnt     = busy ? (N_REQ'(1) << gid_q) : '0;
  assign done    = (state_q == ST_REPORT);
  assign hit     = done & det_match;
  assign done_id = done ? gid_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_ab_detect_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ab_detect_arbiter : vector table, corner sequences and random vs model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ab_detect_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] a_in  = '0;
  logic [3:0] b_in  = '0;
  logic [3:0] gnt;
  logic       busy, done, hit;
  logic [1:0] done_id;

  int n_checks = 0;
  int n_errors = 0;

  ab_detect_arbiter #(.N_REQ(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .hit     (hit),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic       busy;
    logic       done;
    logic       hit;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[20];

  // Transaction-level reference: a transaction lasts three cycles after the
  // grant edge; result is A of cycle 1 AND B of cycle 2 for the winner.
  bit m_active;
  int m_age;
  int m_w;
  int m_last;
  bit m_a;
  bit m_hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_age    = 0;
    m_w      = 0;
    m_last   = 3;
    m_hit    = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b);
    if (!m_active) begin
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_last + i) % 4;
        if (!m_active && r[c]) begin
          m_active = 1'b1;
          m_w      = c;
          m_last   = c;
          m_age    = 1;
        end
      end
    end else begin
      if (m_age == 1) m_a = a[m_w];
      if (m_age == 2) m_hit = m_a && b[m_w];
      m_age++;
      if (m_age > 3) m_active = 1'b0;
    end
  endtask

  task automatic model_check(input string tag);
    logic [3:0] eg;
    bit         ed;
    eg = m_active ? (4'b0001 << m_w) : 4'b0000;
    ed = m_active && (m_age == 3);
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".busy"},    32'(busy),    32'(m_active));
    chk({tag, ".done"},    32'(done),    32'(ed));
    chk({tag, ".hit"},     32'(hit),     32'(ed && m_hit));
    chk({tag, ".done_id"}, 32'(done_id), ed ? 32'(m_w) : 32'd0);
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b);
    req  = r;
    a_in = a;
    b_in = b;
    @(posedge clk);
    model_edge(r, a, b);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.hit", 32'(hit), 32'd0);
    chk("rst.done_id", 32'(done_id), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int onehot_id(input logic [3:0] v);
    int id;
    id = -1;
    for (int i = 0; i < 4; i++) if (v[i]) id = i;
    return id;
  endfunction

  int         gnt_ids[$];
  int         gnt_cyc[$];
  logic [3:0] prev_gnt;
  int         done_ids[$];

  initial begin
    // r, a, b -> gnt, busy, done, hit, done_id observed after the edge
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 2'd0};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[4]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[5]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[12] = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[13] = '{4'b0000, 4'b0111, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0111, 4'b1000, 1'b1, 1'b1, 1'b0, 2'd3};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[16] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[17] = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d.gnt", i),     32'(gnt),     32'(tbl[i].gnt));
      chk($sformatf("tbl%0d.busy", i),    32'(busy),    32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i),    32'(done),    32'(tbl[i].done));
      chk($sformatf("tbl%0d.hit", i),     32'(hit),     32'(tbl[i].hit));
      chk($sformatf("tbl%0d.done_id", i), 32'(done_id), 32'(tbl[i].id));
    end

    // All requesters held: grants rotate 0,1,2,3,0 every four cycles
    do_reset();
    prev_gnt = '0;
    for (int c = 0; c < 18; c++) begin
      drive(4'b1111, 4'b1111, 4'b1111);
      model_check("rr");
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        gnt_ids.push_back(onehot_id(gnt));
        gnt_cyc.push_back(c);
      end
      if (done) done_ids.push_back(int'(done_id));
      prev_gnt = gnt;
    end
    chk("rr.n_grants", 32'(gnt_ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_ids.size(); i++) begin
      chk($sformatf("rr.order%0d", i), 32'(gnt_ids[i]), 32'(i % 4));
      if (i > 0) chk($sformatf("rr.period%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd4);
    end
    chk("rr.n_done", 32'(done_ids.size()), 32'd4);
    for (int i = 0; i < 4 && i < done_ids.size(); i++)
      chk($sformatf("rr.done_id%0d", i), 32'(done_ids[i]), 32'(i));

    // Reset during SAMP_B discards the transaction
    do_reset();
    drive(4'b0010, 4'b0000, 4'b0000);
    drive(4'b0000, 4'b0010, 4'b0000);
    chk("mid.pre_busy", 32'(busy), 32'd1);
    b_in  = 4'b0010;
    rst_n = 1'b0;
    #1;
    chk("mid.async_gnt", 32'(gnt), 32'd0);
    chk("mid.async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    chk("mid.no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    model_reset();
    drive(4'b0010, 4'b0000, 4'b0000);
    chk("mid.regrant1", 32'(gnt), 32'b0010);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 4'b1111, 4'b1111);
      model_check("mid");
    end
    do_reset();
    drive(4'b0011, 4'b0000, 4'b0000);
    chk("mid.regrant0", 32'(gnt), 32'b0001);

    // Randomised traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      drive(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      model_check("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
